instruction_fetch: RTL and testbench

//   IF stage of the 5-stage MIPS-Lite pipeline (no-forwarding build).
//   - Owns the PC and drives the address of the combinational instructionMemory.
//   - Captures the returned word into the IF/ID pipeline register.
//   - Honours stalls from the ID-stage hazard unit and redirects from branch/jump resolution.
//   - Stops fetching after a HALT instruction.

---
 rtl/instruction_fetch_pkg.sv | 23 ++
 rtl/instruction_fetch_if.sv | 11 +
 rtl/instruction_fetch_if_id_register.sv | 28 ++
 rtl/instruction_fetch.sv | 114 +++++++++++
 tb/tb_instruction_fetch.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the MIPS-Lite IF stage: address/instruction widths,
// HALT opcode, fetch FSM states and the IF/ID pipeline register layout.
package instruction_fetch_pkg;

    localparam int unsigned ADDRESSWIDTH = 32;

    typedef logic [31:0] Instruct;

    localparam logic [5:0] OP_HALT   = 6'b010001;
    localparam Instruct    NOP_INSTR = '0;

    typedef enum logic {FETCH_RUN, FETCH_HALTED} fetch_state_e;

    typedef struct packed {
        Instruct                 instr;
        logic [ADDRESSWIDTH-1:0] pc;
        logic [ADDRESSWIDTH-1:0] pc4;
        logic                    valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the combinational
// instructionMemory (slave).
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic [ADDRESSWIDTH-1:0] imem_addr_o;
    Instruct                 imem_instr_i;

    modport master (output imem_addr_o, input imem_instr_i);
    modport slave  (input imem_addr_o, output imem_instr_i);
endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: flush to bubble beats load, otherwise hold.
// Async active-low reset clears it to a bubble.
module if_id_register
    import instruction_fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load,
    input  logic  i_flush,
    input  ifid_t i_d,
    output ifid_t o_q
);

    ifid_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= IFID_BUBBLE;
        end else if (i_flush) begin
            r_q <= IFID_BUBBLE;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS-Lite IF stage: PC, RUN/HALTED fetch FSM, redirect/stall priority and IF/ID register.
// Optional FETCH_STATS_EN adds saturating fetch/stall counters.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDRESSWIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]              HALT_OPCODE = OP_HALT
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [ADDRESSWIDTH-1:0] redirect_pc_i,
    instruction_fetch_if.master     imem,
    output Instruct                 ifid_instr_o,
    output logic [ADDRESSWIDTH-1:0] ifid_pc_o,
    output logic [ADDRESSWIDTH-1:0] ifid_pc4_o,
    output logic                    ifid_valid_o,
    output logic                    halted_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]             fetch_count_o,
    output logic [31:0]             stall_count_o
`endif
);

    fetch_state_e            r_state;
    fetch_state_e            w_state_next;
    logic [ADDRESSWIDTH-1:0] r_pc;
    logic [ADDRESSWIDTH-1:0] w_pc_next;
    logic [ADDRESSWIDTH-1:0] w_pc4;
    logic [ADDRESSWIDTH-1:0] w_redir_pc;
    logic                    w_load;
    logic                    w_flush;
    ifid_t                   w_ifid_d;
    ifid_t                   w_ifid_q;

    assign w_pc4      = r_pc + ADDRESSWIDTH'(4);
    assign w_redir_pc = redirect_pc_i & ~ADDRESSWIDTH'(3);
    assign w_ifid_d   = '{instr: imem.imem_instr_i, pc: r_pc, pc4: w_pc4, valid: 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Redirect outranks stall and HALTED so a wrong-path HALT can always be squashed.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        if (redirect_i) begin
            w_pc_next    = w_redir_pc;
            w_flush      = 1'b1;
            w_state_next = FETCH_RUN;
        end else if (stall_i) begin
            w_pc_next = r_pc;
        end else if (r_state == FETCH_RUN) begin
            w_load = 1'b1;
            if (imem.imem_instr_i[31:26] == HALT_OPCODE) begin
                w_state_next = FETCH_HALTED;
            end else begin
                w_pc_next = w_pc4;
            end
        end else begin
            w_flush = 1'b1;
        end
    end

    if_id_register u_ifid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign imem.imem_addr_o = r_pc;
    assign ifid_instr_o     = w_ifid_q.instr;
    assign ifid_pc_o        = w_ifid_q.pc;
    assign ifid_pc4_o       = w_ifid_q.pc4;
    assign ifid_valid_o     = w_ifid_q.valid;
    assign halted_o         = (r_state == FETCH_HALTED);

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_load && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (stall_i && !redirect_i && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count_o = r_fetch_count;
    assign stall_count_o = r_stall_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory and
// an IF/ID scoreboard; also checks FETCH_STATS_EN counters when that macro is set.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    stall_i = 1'b0;
    logic                    redirect_i = 1'b0;
    logic [ADDRESSWIDTH-1:0] redirect_pc_i = '0;
    Instruct                 ifid_instr_o;
    logic [ADDRESSWIDTH-1:0] ifid_pc_o;
    logic [ADDRESSWIDTH-1:0] ifid_pc4_o;
    logic                    ifid_valid_o;
    logic                    halted_o;
`ifdef FETCH_STATS_EN
    logic [31:0]             fetch_count_o;
    logic [31:0]             stall_count_o;
`endif

    instruction_fetch_if u_bus ();

    Instruct mem [0:63];
    assign u_bus.imem_instr_i = mem[6'(u_bus.imem_addr_o >> 2)];

    instruction_fetch #(.RESET_PC('0), .HALT_OPCODE(OP_HALT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (u_bus.master),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_valid_o  (ifid_valid_o),
        .halted_o      (halted_o)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count_o (fetch_count_o),
        .stall_count_o (stall_count_o)
`endif
    );

    always #5 clk = ~clk;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    ifid_t                   sb_q[$];
    ifid_t                   m_ifid;
    logic [ADDRESSWIDTH-1:0] m_pc;
    logic                    m_halted;
    int unsigned             m_fetches;
    int unsigned             m_stalls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = '0;
        m_halted  = 1'b0;
        m_ifid    = '0;
        m_fetches = 0;
        m_stalls  = 0;
        sb_q.delete();
    endtask

    // Drive one cycle of inputs, predict the edge, then compare just after it.
    task automatic step(input logic st, input logic rd, input logic [ADDRESSWIDTH-1:0] rpc);
        Instruct w;
        ifid_t   e;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        if (rd) begin
            m_pc     = {rpc[ADDRESSWIDTH-1:2], 2'b00};
            m_ifid   = '0;
            m_halted = 1'b0;
        end else if (st) begin
            m_stalls++;
        end else if (!m_halted) begin
            w      = mem[6'(m_pc >> 2)];
            m_ifid = '{instr: w, pc: m_pc, pc4: m_pc + 32'd4, valid: 1'b1};
            m_fetches++;
            if (w[31:26] == OP_HALT) m_halted = 1'b1;
            else m_pc = m_pc + 32'd4;
        end else begin
            m_ifid = '0;
        end
        sb_q.push_back(m_ifid);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("ifid_instr", ifid_instr_o, e.instr);
        chk("ifid_pc", ifid_pc_o, e.pc);
        chk("ifid_pc4", ifid_pc4_o, e.pc4);
        chk("ifid_valid", 32'(ifid_valid_o), 32'(e.valid));
        chk("imem_addr", u_bus.imem_addr_o, m_pc);
        chk("halted", 32'(halted_o), 32'(m_halted));
        stall_i    = 1'b0;
        redirect_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | 32'(i * 3 + 1);
        mem[4] = {OP_HALT, 26'h0AB_CDEF};
        model_reset();

        #12;
        chk("rst_addr", u_bus.imem_addr_o, 32'h0);
        chk("rst_valid", 32'(ifid_valid_o), 32'h0);
        chk("rst_instr", ifid_instr_o, 32'h0);
        chk("rst_halted", 32'(halted_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, '0);
        chk("run_addr4", u_bus.imem_addr_o, 32'h4);
        chk("run_pc0", ifid_pc_o, 32'h0);
        step(0, 0, '0);
        chk("run_addr8", u_bus.imem_addr_o, 32'h8);
        chk("run_instr1", ifid_instr_o, 32'h2000_0004);

        step(1, 0, '0);
        step(1, 0, '0);
        chk("stall_addr", u_bus.imem_addr_o, 32'h8);
        chk("stall_pc", ifid_pc_o, 32'h4);
        step(0, 0, '0);
        chk("resume_addr", u_bus.imem_addr_o, 32'hC);
        chk("resume_instr2", ifid_instr_o, 32'h2000_0007);
        step(0, 0, '0);
        chk("run_addr16", u_bus.imem_addr_o, 32'h10);

        step(0, 0, '0);
        chk("halt_instr", ifid_instr_o, {OP_HALT, 26'h0AB_CDEF});
        chk("halt_valid", 32'(ifid_valid_o), 32'h1);
        chk("halt_flag", 32'(halted_o), 32'h1);
        step(0, 0, '0);
        step(0, 0, '0);
        chk("halt_hold_pc", u_bus.imem_addr_o, 32'h10);
        chk("halt_bubble", 32'(ifid_valid_o), 32'h0);

        step(0, 1, 32'h0);
        chk("unhalt", 32'(halted_o), 32'h0);
        step(0, 0, '0);
        chk("refetch0", ifid_pc_o, 32'h0);

        step(1, 1, 32'h41);
        chk("redir_addr", u_bus.imem_addr_o, 32'h40);
        chk("redir_flush", 32'(ifid_valid_o), 32'h0);
        step(0, 0, '0);
        chk("redir_ifid_pc", ifid_pc_o, 32'h40);

        step(0, 1, 32'h44);
        chk("redir_same_flush", 32'(ifid_valid_o), 32'h0);

        step(0, 1, 32'hFFFF_FFFC);
        step(0, 0, '0);
        chk("wrap_addr", u_bus.imem_addr_o, 32'h0);
        chk("wrap_pc4", ifid_pc4_o, 32'h0);

        step(1, 1, 32'h10);
        step(1, 0, '0);
        chk("halt_stall_valid", 32'(ifid_valid_o), 32'h0);
        chk("halt_stall_run", 32'(halted_o), 32'h0);
        step(0, 0, '0);
        chk("halt_after_stall", 32'(halted_o), 32'h1);

`ifdef FETCH_STATS_EN
        chk("stall_count", stall_count_o, 32'(m_stalls));
        chk("fetch_count", fetch_count_o, 32'(m_fetches));
`endif

        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_addr", u_bus.imem_addr_o, 32'h0);
        chk("arst_valid", 32'(ifid_valid_o), 32'h0);
        chk("arst_instr", ifid_instr_o, 32'h0);
        chk("arst_pc", ifid_pc_o, 32'h0);
        chk("arst_pc4", ifid_pc4_o, 32'h0);
        chk("arst_halted", 32'(halted_o), 32'h0);
`ifdef FETCH_STATS_EN
        chk("arst_stall_count", stall_count_o, 32'h0);
        chk("arst_fetch_count", fetch_count_o, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, '0);
        step(0, 0, '0);
        chk("post_rst_pc", ifid_pc_o, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
